delay_chain: RTL and testbench



---
 rtl/delay_chain_pkg.sv | 14 +
 rtl/delay_stage.sv | 22 ++
 rtl/delay_chain.sv | 71 +++++++
 tb/tb_delay_chain.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/delay_chain_pkg.sv
// Shared defaults and the fill-counter width helper for the delay_chain line.
package delay_chain_pkg;

    localparam int DEFAULT_DW  = 8;
    localparam int DEFAULT_LEN = 5;

    // Counter must hold 0..len inclusive; never narrower than one bit.
    function automatic int fill_w(input int len);
        int w;
        w = $clog2(len + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : delay_chain_pkg

// File: rtl/delay_stage.sv
// One DW-bit pipeline register with synchronous reset and shift enable.
module delay_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    // NOTE: sequential state uses <= so every stage samples its neighbour's
    // pre-edge value; blocking here would collapse the chain into one stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : delay_stage

// File: rtl/delay_chain.sv
// Shift-register delay line: LEN enabled cycles of latency, per-stage taps, fill flag.
module delay_chain
    import delay_chain_pkg::*;
#(
    parameter int DW  = DEFAULT_DW,
    parameter int LEN = DEFAULT_LEN
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    input  logic [DW-1:0]                        in,
    output logic [DW-1:0]                        out,
    output logic [((LEN > 0) ? LEN*DW : 1)-1:0]  taps,
    output logic                                 out_valid
);

    if (DW < 1) begin : g_bad_dw
        $error("delay_chain: DW must be >= 1 (got %0d)", DW);
    end
    if (LEN < 0) begin : g_bad_len
        $error("delay_chain: LEN must be >= 0 (got %0d)", LEN);
    end

    if (LEN == 0) begin : g_bypass
        // Zero-length line is a wire; taps degenerates to a 1-bit dummy.
        assign out       = in;
        assign taps      = 1'b0;
        assign out_valid = 1'b1;
    end else begin : g_chain
        localparam int              FW       = fill_w(LEN);
        localparam logic [FW-1:0]   FILL_MAX = FW'(LEN);

        logic [DW-1:0] stage_q [LEN];
        logic [FW-1:0] fill;

        for (genvar k = 0; k < LEN; k++) begin : g_stage
            logic [DW-1:0] stage_d;

            if (k == 0) begin : g_head
                assign stage_d = in;
            end else begin : g_body
                assign stage_d = stage_q[k-1];
            end

            delay_stage #(
                .DW (DW)
            ) u_stage (
                .clk (clk),
                .rst (rst),
                .en  (en),
                .d   (stage_d),
                .q   (stage_q[k])
            );

            assign taps[k*DW +: DW] = stage_q[k];
        end

        // Saturates at LEN so out_valid stays high until the next reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                fill <= '0;
            end else if (en && (fill != FILL_MAX)) begin
                fill <= fill + 1'b1;
            end
        end

        assign out       = stage_q[LEN-1];
        assign out_valid = (fill == FILL_MAX);
    end

endmodule : delay_chain

// File: tb/tb_delay_chain.sv
// Directed bench for delay_chain: LEN=5 main instance plus LEN=0 and LEN=1 builds.
module tb_delay_chain;

    localparam int DW  = 8;
    localparam int LEN = 5;

    logic          clk;
    logic          rst;
    logic          en;
    logic [DW-1:0] din;

    logic [DW-1:0]     out5;
    logic [LEN*DW-1:0] taps5;
    logic              ov5;

    logic [DW-1:0] out0;
    logic          taps0;
    logic          ov0;

    logic [DW-1:0] out1;
    logic [DW-1:0] taps1;
    logic          ov1;

    int n_cmp;
    int n_err;

    // Reference model of the LEN=5 and LEN=1 lines.
    logic [DW-1:0] m_s [LEN];
    int            m_fill;
    logic [DW-1:0] m1;
    int            m1_fill;

    delay_chain #(.DW(DW), .LEN(LEN)) u_dut5 (
        .clk (clk), .rst (rst), .en (en), .in (din),
        .out (out5), .taps (taps5), .out_valid (ov5)
    );

    delay_chain #(.DW(DW), .LEN(0)) u_dut0 (
        .clk (clk), .rst (rst), .en (en), .in (din),
        .out (out0), .taps (taps0), .out_valid (ov0)
    );

    delay_chain #(.DW(DW), .LEN(1)) u_dut1 (
        .clk (clk), .rst (rst), .en (en), .in (din),
        .out (out1), .taps (taps1), .out_valid (ov1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the model on the edge, then compare all outputs.
    task automatic tick(input logic r, input logic e, input logic [DW-1:0] d);
        logic [LEN*DW-1:0] exp_taps;
        rst = r;
        en  = e;
        din = d;
        #1;
        check("len0_out", 64'(out0), 64'(d));
        check("len0_valid", 64'(ov0), 64'd1);
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < LEN; k++) m_s[k] = '0;
            m_fill  = 0;
            m1      = '0;
            m1_fill = 0;
        end else if (e) begin
            for (int k = LEN-1; k > 0; k--) m_s[k] = m_s[k-1];
            m_s[0]  = d;
            m_fill  = (m_fill < LEN) ? m_fill + 1 : LEN;
            m1      = d;
            m1_fill = 1;
        end
        #1;
        for (int k = 0; k < LEN; k++) exp_taps[k*DW +: DW] = m_s[k];
        check("out", 64'(out5), 64'(m_s[LEN-1]));
        check("taps", 64'(taps5), 64'(exp_taps));
        check("out_valid", 64'(ov5), 64'(m_fill == LEN));
        check("len1_out", 64'(out1), 64'(m1));
        check("len1_valid", 64'(ov1), 64'(m1_fill == 1));
    endtask

    initial begin
        logic [DW-1:0] dir_in  [6];
        logic [DW-1:0] dir_out [6];
        logic          dir_ov  [6];
        logic          tog     [4];

        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        en  = 1'b0;
        din = '0;
        for (int k = 0; k < LEN; k++) m_s[k] = 'x;
        m_fill  = 0;
        m1      = 'x;
        m1_fill = 0;

        dir_in  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        dir_out = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
        dir_ov  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tog     = '{1'b1, 1'b0, 1'b0, 1'b1};

        // Reset for three cycles.
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 8'h00);
        check("rst_out", 64'(out5), 64'h0);
        check("rst_taps", 64'(taps5), 64'h0);
        check("rst_valid", 64'(ov5), 64'h0);

        // Directed fill: 11 emerges after the fifth enabled edge.
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b1, dir_in[i]);
            check("dir_out", 64'(out5), 64'(dir_out[i]));
            check("dir_valid", 64'(ov5), 64'(dir_ov[i]));
        end
        check("dir_tap0", 64'(taps5[0 +: DW]), 64'h66);
        check("dir_tap4", 64'(taps5[4*DW +: DW]), 64'h22);

        // Random data, en held high.
        for (int i = 0; i < 40; i++) tick(1'b0, 1'b1, DW'($urandom_range(0, 255)));

        // en pattern 1,0,0,1 with a known ramp; holds and order checked by model.
        for (int i = 0; i < 24; i++) tick(1'b0, tog[i % 4], 8'hA0 + 8'(i));
        check("gap_valid_held", 64'(ov5), 64'h1);

        // Mid-stream reset with en high discards everything.
        tick(1'b1, 1'b1, 8'h5A);
        check("mid_rst_out", 64'(out5), 64'h0);
        check("mid_rst_taps", 64'(taps5), 64'h0);
        check("mid_rst_valid", 64'(ov5), 64'h0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 8'hC0 + 8'(i));
        check("refill_4_valid", 64'(ov5), 64'h0);
        tick(1'b0, 1'b0, 8'hEE);
        check("refill_gap_valid", 64'(ov5), 64'h0);
        tick(1'b0, 1'b1, 8'hC4);
        check("refill_5_valid", 64'(ov5), 64'h1);
        check("refill_5_out", 64'(out5), 64'hC0);

        // rst beats en: FF must not be captured.
        tick(1'b1, 1'b1, 8'hFF);
        check("rst_en_taps", 64'(taps5), 64'h0);
        tick(1'b0, 1'b1, 8'h01);
        check("post_rst_tap0", 64'(taps5[0 +: DW]), 64'h01);
        check("post_rst_tap1", 64'(taps5[1*DW +: DW]), 64'h00);
        check("post_rst_len1", 64'(out1), 64'h01);

        // LEN=0 is combinational regardless of rst/en.
        rst = 1'b0;
        en  = 1'b0;
        din = 8'hA5;
        #1;
        check("len0_a5", 64'(out0), 64'hA5);
        check("len0_a5_valid", 64'(ov0), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_delay_chain
